// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin arbiter that sequences commands through one shared
// myNBitALUv2 and returns registered result/overflow/zero on the owner's channel.

module myNBitALUv2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             ainvert,
  input  logic             bnegate,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero
);
  logic [WIDTH-1:0] a, b, sum;
  logic             c_msb, c_out, set;

  // The MSB add is split out so overflow is the carry-in/carry-out mismatch of
  // the sign bit, and SLT uses the overflow-corrected sign of a - b.
  always_comb begin
    a      = ainvert ? ~in1 : in1;
    b      = bnegate ? ~in2 : in2;
    {c_msb, sum[WIDTH-2:0]} = {1'b0, a[WIDTH-2:0]} + {1'b0, b[WIDTH-2:0]} + WIDTH'(bnegate);
    {c_out, sum[WIDTH-1]}   = 2'(a[WIDTH-1]) + 2'(b[WIDTH-1]) + 2'(c_msb);
    overflow = c_msb ^ c_out;
    set      = sum[WIDTH-1] ^ overflow;
    result   = '0;
    case (op)
      2'b00:   result = a & b;
      2'b01:   result = a | b;
      2'b10:   result = sum;
      default: result = {{(WIDTH-1){1'b0}}, set};
    endcase
    zero = ~|result;
  end
endmodule

module alu_req_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_cmd0,
  input  logic [3:0]       req_cmd1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             ptr, owner, grant;
  logic [3:0]       cmd_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow, alu_zero;

  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ptr;
      default: grant = 1'b0;
    endcase
  end

  // Reset gates the handshake so a valid request can never be accepted on a reset edge.
  assign req_ready = (state == IDLE && !reset && req_valid[grant]) ?
                     (grant ? 2'b10 : 2'b01) : 2'b00;

  myNBitALUv2 #(.WIDTH(WIDTH)) u_alu (
    .in1      (a_q),
    .in2      (b_q),
    .ainvert  (cmd_q[3]),
    .bnegate  (cmd_q[2]),
    .op       (cmd_q[1:0]),
    .result   (alu_result),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  // NOTE: all state below uses non-blocking assignments so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      owner        <= 1'b0;
      cmd_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid    <= 2'b00;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            owner <= grant;
            cmd_q <= grant ? req_cmd1 : req_cmd0;
            a_q   <= grant ? req_a1   : req_a0;
            b_q   <= grant ? req_b1   : req_b0;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result   <= alu_result;
          rsp_overflow <= alu_overflow;
          rsp_zero     <= alu_zero;
          rsp_valid    <= {owner, ~owner};
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            ptr       <= ~owner;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-requester arbiter and sequencer for the shared `myNBitALUv2` datapath. Each requester submits a command (operands plus ALU control bits) over a valid/ready handshake. The block grants one requester at a time using round-robin priority, runs the operation through a single internally instantiated ALU, and returns the registered result, overflow and zero flags on the winning requester's response channel. It sits between instruction-issue/address-generation logic and the ALU, so one ALU can serve several clients.

## Interface
- `WIDTH`, 32, operand/result width; passed to the internal `myNBitALUv2`
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  2  bit i: requester i presents a command
- `req_ready`  out  2  bit i: command from requester i accepted this cycle
- `req_cmd0`, `req_cmd1`  in  4  `{ainvert, bnegate, op[1:0]}` for requester 0 / 1
- `req_a0`, `req_a1`  in  WIDTH  first operand (ALU `in1`) for requester 0 / 1
- `req_b0`, `req_b1`  in  WIDTH  second operand (ALU `in2`) for requester 0 / 1
- `rsp_valid`  out  2  bit i: response pending for requester i
- `rsp_ready`  in  2  bit i: requester i consumes its response
- `rsp_result`  out  WIDTH  registered ALU result; shared bus, qualified by `rsp_valid`
- `rsp_overflow`  out  1  registered ALU overflow
- `rsp_zero`  out  1  registered ALU zero
- `busy`  out  1  high whenever state is not IDLE

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant: if only one `req_valid` bit is set, that requester wins. If both are set, the requester named by priority pointer `ptr` wins.
  - `req_ready[g]=1` for the granted g only, and only in IDLE. The other bit is 0.
  - On accept (`req_valid[g] & req_ready[g]`), latch the cmd, a and b for g, set `owner=g`, and go to EXEC.
- **EXEC**
  - The latched operands and control drive the ALU.
  - At the clock edge, capture result, overflow and zero into the response registers, then go to RESP.
- **RESP**
  - `rsp_valid[owner]=1`; the other bit is 0.
  - Response registers hold steady until `rsp_ready[owner]=1`.
  - On that edge: go to IDLE and set `ptr = ~owner`.
  - `rsp_ready` of the non-owner is ignored.
- The arbiter never alters ALU semantics. SLT (`op=11`), overflow and zero are passed through exactly as `myNBitALUv2` produces them.
- Requester inputs are sampled only at the accept edge. Later changes do not affect an operation in flight.
- A requester may drop `req_valid` before it is granted; no command is latched for it.

## Timing
- Reset values: state=IDLE, `ptr=0`, `owner=0`, `req_ready=2'b00` during the reset cycle, `rsp_valid=2'b00`, `rsp_result=0`, `rsp_overflow=0`, `rsp_zero=0`, `busy=0`.
- Latency: accept edge at cycle N, `rsp_valid` high from cycle N+2.
- Minimum issue interval is 3 cycles: accept, EXEC, then RESP consumed in the same cycle. The next accept can occur in the cycle after the response handshake edge.
- Backpressure:
  - `rsp_valid` stays high indefinitely while `rsp_ready[owner]=0`.
  - No new command is accepted during EXEC or RESP.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- Reset asserted in EXEC or RESP:
  - The block returns to IDLE at that edge with the outputs at their reset values.
  - The in-flight result is discarded and never presented.
- Simultaneous `req_valid` and `reset`: reset wins; no accept occurs.

## Test plan
- After reset, only requester 0 sends ADD `7FFFFFFF+00000001` (cmd `0010`). Required: `rsp_valid=01` two cycles after accept, result `80000000`, overflow 1, zero 0.
- Only requester 1 sends SUB `0000000A-00000002` (cmd `0110`). Required: `rsp_valid=10`, result `00000008`, overflow 0, zero 0.
- Both requesters valid in the first cycle after reset: 0 sends AND `0000000F&0000000A`, 1 sends OR `7FFFFFFE|A0A0A0A0`. Required: requester 0 is served first with result `0000000A`, then requester 1 with result `FFFFFFFE`.
- Both requesters valid continuously for 6 operations, with `rsp_ready=11`. Required: grant order 0,1,0,1,0,1, and one accept every 3 cycles.
- Hold `rsp_ready[0]=0` for 5 cycles on a SUB `00000001-00000001`. Required:
  - `rsp_valid=01` holds with result `00000000`, zero 1.
  - `req_ready=00` throughout while requester 1 waits.
  - Requester 1 is granted in the cycle after the handshake edge.
- Assert `reset` during EXEC of ADD `00000001+00000001`. Required: next cycle state is IDLE, `rsp_valid=00`, `busy=0`, and the result `00000002` is never presented.
